axi_ar_arbiter: RTL
===================

// Module: axi_ar_arbiter
// PURPOSE
//   Read-address arbiter for the 2-master / 3-slave AXI interconnect (S0, S1, default slave).
//   Grants one master's AR request at a time (round-robin), decodes its address to a one-hot slave
//   select and routes the ARVALID/ARREADY handshake. Holds the grant until the read burst's last beat completes.
//   Supplies grant/slave_sel to the AR payload mux and to the read-data return path; single outstanding read.
// PARAMETERS
//   ADDR_BITS   32    address width of ARADDR_M0/ARADDR_M1
//   TO_CYCLES   256   watchdog: max cycles in DATA before abort (>=2)
//   TW          $clog2(TO_CYCLES+1)   (localparam) watchdog counter width
// PORTS
//   clk            in   1          clock, all state on posedge
//   rst            in   1          synchronous active-low reset
//   ARVALID_M0     in   1          master 0 AR request
//   ARADDR_M0      in   ADDR_BITS  master 0 read address
//   ARREADY_M0     out  1          AR accept to master 0
//   ARVALID_M1     in   1          master 1 AR request
//   ARADDR_M1      in   ADDR_BITS  master 1 read address
//   ARREADY_M1     out  1          AR accept to master 1
//   ARVALID_S      out  3          AR valid to {default,S1,S0}
//   ARREADY_S      in   3          AR ready from {default,S1,S0}
//   RVALID_M       in   2          R valid seen by {M1,M0}
//   RREADY_M       in   2          R ready from {M1,M0}
//   RLAST_M        in   2          R last seen by {M1,M0}
//   grant          out  2          one-hot owner {M1,M0}; 00 = none (registered)
//   slave_sel      out  3          one-hot target {default,S1,S0}; 000 = none (registered)
//   busy           out  1          state != IDLE
//   timeout_err    out  1          one-cycle pulse on watchdog abort (registered)
// BEHAVIOUR
// - Reset (rst==0 at posedge): state=IDLE, grant=00, slave_sel=000, rr_ptr=0 (M0 first), timer=0,
//   timeout_err=0. Combinational outputs therefore 0: ARVALID_S=000, ARREADY_M0/M1=0, busy=0.
// - States: IDLE -> ADDR -> DATA -> IDLE.
// - IDLE: no ARREADY. If {ARVALID_M1,ARVALID_M0}==01/10, grant that master; if 11, grant M0 when
//   rr_ptr=0, else M1. Latch grant and decode the granted ARADDR into slave_sel; next state ADDR.
//   Arbitration latency: 1 cycle (earliest AR handshake is the cycle after request seen).
// - Decode (ARADDR[ADDR_BITS-1:16]): ==0 -> S0 (001); ==1 -> S1 (010); else -> default (100).
// - ADDR: ARVALID_S = slave_sel & {3{ARVALID of granted master}};
//   ARREADY of granted master = |(ARREADY_S & slave_sel); other master's ARREADY=0.
//   On granted ARVALID & ARREADY: next state DATA, timer<=0. Else stay in ADDR (no timeout here).
// - DATA: ARVALID_S=000, both ARREADY=0. done = RVALID_M[g] & RREADY_M[g] & RLAST_M[g], g = granted index.
//   done -> IDLE, grant<=00, slave_sel<=000, rr_ptr<= ~g (other master gets priority next).
//   Else timer<=timer+1; if timer==TO_CYCLES-1 and !done: timeout_err<=1 for one cycle, same clearing
//   and rr_ptr update as done, next state IDLE. Timer never wraps.
// - done and timeout in same cycle: done wins, timeout_err stays 0.
// - Non-last beats and beats for the non-granted master do not affect state.
// - Requests arriving during ADDR/DATA wait (ARREADY=0); no request is dropped, only delayed.
// - rr_ptr only updates on completion/abort, never in IDLE without a grant.
// - Reset in any state: next cycle IDLE with reset values; in-flight burst abandoned, no err pulse.
// TESTING
//   1) rst=0 for 2 cycles with ARVALID_M0=ARVALID_M1=1 -> grant=00, ARVALID_S=000, ARREADY_M0/M1=0, busy=0.
//   2) M0 ARADDR=0x0000_0040, ARREADY_S=001 -> cycle+1 grant=01, slave_sel=001, AR handshake;
//      4 R beats with RLAST on beat 4 -> IDLE next cycle, grant=00.
//   3) Both ARVALID held high after reset -> grants M0, M1, M0 in order; each held until its RLAST handshake.
//   4) M1 ARADDR=0x0001_0010 -> slave_sel=010; ARADDR=0x2000_0000 -> slave_sel=100, ARVALID_S=100.
//   5) AR accepted, no RLAST -> timeout_err=1 exactly one cycle on DATA cycle 256 (TO_CYCLES=256); IDLE after.
//   6) RLAST handshake on timeout cycle -> timeout_err=0; rst=0 mid-DATA -> IDLE, all outputs 0 next cycle.

Source files
------------

// File: rtl/axi_ar_arbiter.sv
// Read-address arbiter for a 2-master / 3-slave AXI interconnect.
// Round-robin grant of one AR request at a time, address decode to a one-hot
// slave select, AR handshake routing, and grant hold until the burst's RLAST
// beat (or a watchdog abort).
module axi_ar_arbiter #(
    parameter int unsigned ADDR_BITS = 32,
    parameter int unsigned TO_CYCLES = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ARVALID_M0,
    input  logic [ADDR_BITS-1:0] ARADDR_M0,
    output logic                 ARREADY_M0,
    input  logic                 ARVALID_M1,
    input  logic [ADDR_BITS-1:0] ARADDR_M1,
    output logic                 ARREADY_M1,
    output logic [2:0]           ARVALID_S,
    input  logic [2:0]           ARREADY_S,
    input  logic [1:0]           RVALID_M,
    input  logic [1:0]           RREADY_M,
    input  logic [1:0]           RLAST_M,
    output logic [1:0]           grant,
    output logic [2:0]           slave_sel,
    output logic                 busy,
    output logic                 timeout_err
);

    localparam int unsigned TW = $clog2(TO_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TO_CYCLES - 1);
    localparam logic [ADDR_BITS-17:0] HI_S1 = (ADDR_BITS - 16)'(1);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA
    } state_t;

    state_t        state, state_d;
    logic [1:0]    grant_d;
    logic [2:0]    slave_sel_d;
    logic          rr_ptr, rr_ptr_d;
    logic [TW-1:0] timer, timer_d;
    logic          timeout_err_d;

    logic          g_idx;
    logic          g_arvalid;
    logic          s_ready;
    logic          pick_m1;
    logic          done;

    // Upper address bits select S0 (page 0), S1 (page 1) or the default slave.
    function automatic logic [2:0] decode(input logic [ADDR_BITS-1:0] a);
        if (a[ADDR_BITS-1:16] == '0)
            return 3'b001;
        else if (a[ADDR_BITS-1:16] == HI_S1)
            return 3'b010;
        else
            return 3'b100;
    endfunction

    // Shared decode of the granted master's signals and the arbitration pick.
    always_comb begin
        g_idx     = grant[1];
        g_arvalid = g_idx ? ARVALID_M1 : ARVALID_M0;
        s_ready   = |(ARREADY_S & slave_sel);
        pick_m1   = (ARVALID_M1 & ~ARVALID_M0) | (ARVALID_M1 & ARVALID_M0 & rr_ptr);
        done      = (state == DATA) & RVALID_M[g_idx] & RREADY_M[g_idx] & RLAST_M[g_idx];
    end

    // Next-state logic and the combinational handshake outputs.
    always_comb begin
        state_d       = state;
        grant_d       = grant;
        slave_sel_d   = slave_sel;
        rr_ptr_d      = rr_ptr;
        timer_d       = timer;
        timeout_err_d = 1'b0;
        ARVALID_S     = '0;
        ARREADY_M0    = 1'b0;
        ARREADY_M1    = 1'b0;
        busy          = (state != IDLE);

        unique case (state)
            IDLE: begin
                if (ARVALID_M0 | ARVALID_M1) begin
                    grant_d     = pick_m1 ? 2'b10 : 2'b01;
                    slave_sel_d = decode(pick_m1 ? ARADDR_M1 : ARADDR_M0);
                    state_d     = ADDR;
                end
            end
            ADDR: begin
                ARVALID_S  = slave_sel & {3{g_arvalid}};
                ARREADY_M0 = grant[0] & s_ready;
                ARREADY_M1 = grant[1] & s_ready;
                if (g_arvalid & s_ready) begin
                    state_d = DATA;
                    timer_d = '0;
                end
            end
            DATA: begin
                // done has priority over the watchdog: a last beat on the
                // final allowed cycle completes normally without an error.
                if (done || timer == TIMER_LAST) begin
                    timeout_err_d = ~done;
                    state_d       = IDLE;
                    grant_d       = '0;
                    slave_sel_d   = '0;
                    rr_ptr_d      = ~g_idx;
                end else begin
                    timer_d = timer + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            grant       <= '0;
            slave_sel   <= '0;
            rr_ptr      <= 1'b0;
            timer       <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_d;
            grant       <= grant_d;
            slave_sel   <= slave_sel_d;
            rr_ptr      <= rr_ptr_d;
            timer       <= timer_d;
            timeout_err <= timeout_err_d;
        end
    end

endmodule
